// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU control codes and ALU B-operand selects.
package mc_pkg;

    localparam int unsigned IR_W     = 16;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned ALUC_W   = 4;
    localparam int unsigned SRCB_W   = 2;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_NAND = 4'b0101;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b0110;
    localparam logic [OP_W-1:0] OP_ADDI = 4'b0111;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'b1000;
    localparam logic [OP_W-1:0] OP_BNE  = 4'b1001;

    localparam logic [IR_W-1:0] HALT_WORD = 16'hFFFF;

    // {ainvert, binvert, op[1:0]}
    localparam logic [ALUC_W-1:0] ALUC_AND  = 4'b0000;
    localparam logic [ALUC_W-1:0] ALUC_OR   = 4'b0001;
    localparam logic [ALUC_W-1:0] ALUC_ADD  = 4'b0010;
    localparam logic [ALUC_W-1:0] ALUC_SUB  = 4'b0110;
    localparam logic [ALUC_W-1:0] ALUC_SLT  = 4'b0111;
    localparam logic [ALUC_W-1:0] ALUC_NOR  = 4'b1100;
    localparam logic [ALUC_W-1:0] ALUC_NAND = 4'b1101;

    localparam logic [SRCB_W-1:0] SRCB_RD2    = 2'b00;
    localparam logic [SRCB_W-1:0] SRCB_TWO    = 2'b01;
    localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_op_decoder.sv
// Combinational opcode decoder: ALU operation, destination select and
// instruction class for the multicycle controller.
module mc_op_decoder
    import mc_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [3:0] alu_ctrl,
    output logic       reg_dst,
    output logic       use_imm,
    output logic       is_branch,
    output logic       is_alu
);

    always_comb begin
        alu_ctrl  = ALUC_ADD;
        reg_dst   = 1'b0;
        use_imm   = 1'b0;
        is_branch = 1'b0;
        is_alu    = 1'b0;
        case (opcode)
            OP_ADD:  begin alu_ctrl = ALUC_ADD;  is_alu = 1'b1; reg_dst = 1'b1; end
            OP_SUB:  begin alu_ctrl = ALUC_SUB;  is_alu = 1'b1; reg_dst = 1'b1; end
            OP_AND:  begin alu_ctrl = ALUC_AND;  is_alu = 1'b1; reg_dst = 1'b1; end
            OP_OR:   begin alu_ctrl = ALUC_OR;   is_alu = 1'b1; reg_dst = 1'b1; end
            OP_NOR:  begin alu_ctrl = ALUC_NOR;  is_alu = 1'b1; reg_dst = 1'b1; end
            OP_NAND: begin alu_ctrl = ALUC_NAND; is_alu = 1'b1; reg_dst = 1'b1; end
            OP_SLT:  begin alu_ctrl = ALUC_SLT;  is_alu = 1'b1; reg_dst = 1'b1; end
            // addi writes IR[9:8] and takes the sign-extended immediate
            OP_ADDI: begin alu_ctrl = ALUC_ADD;  is_alu = 1'b1; use_imm = 1'b1; end
            OP_BEQ:  begin alu_ctrl = ALUC_SUB;  is_branch = 1'b1; end
            OP_BNE:  begin alu_ctrl = ALUC_SUB;  is_branch = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM: fetch/decode/execute/writeback/branch
// sequencing with combinational datapath controls and a retired-instruction counter.
module multicycle_control
    import mc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        imem_ready,
    input  logic [15:0] IR,
    input  logic        Zero,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUControl,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        halted,
    output logic [2:0]  state,
    output logic [15:0] instr_count
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  instr_count_q, instr_count_d;
    logic              retire;

    logic [ALUC_W-1:0] dec_alu_ctrl;
    logic              dec_reg_dst;
    logic              dec_use_imm;
    logic              dec_is_branch;
    logic              dec_is_alu;

    mc_op_decoder u_op_decoder (
        .opcode    (IR[15:12]),
        .alu_ctrl  (dec_alu_ctrl),
        .reg_dst   (dec_reg_dst),
        .use_imm   (dec_use_imm),
        .is_branch (dec_is_branch),
        .is_alu    (dec_is_alu)
    );

    // State and counter advance on the falling clock edge.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALUC_AND;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    ALUSrcB    = SRCB_TWO;
                    ALUControl = ALUC_ADD;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // PC + (imm << 1) is captured by the datapath as the branch target
                ALUSrcB    = SRCB_IMM_SH;
                ALUControl = ALUC_ADD;
                if (IR == HALT_WORD) begin
                    state_d = ST_HALT;
                end else if (dec_is_alu) begin
                    state_d = ST_EXEC;
                end else if (dec_is_branch) begin
                    state_d = ST_BRANCH;
                end else begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = dec_use_imm ? SRCB_IMM : SRCB_RD2;
                ALUControl = dec_alu_ctrl;
                state_d    = ST_WB;
            end
            ST_WB: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = dec_use_imm ? SRCB_IMM : SRCB_RD2;
                ALUControl = dec_alu_ctrl;
                RegWrite   = 1'b1;
                RegDst     = dec_reg_dst;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_RD2;
                ALUControl = ALUC_SUB;
                PCSrc      = 1'b1;
                PCWrite    = (IR[15:12] == OP_BNE) ? ~Zero : Zero;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        instr_count_d = instr_count_q;
        if (retire) instr_count_d = instr_count_q + CNT_W'(1);
    end

    assign state       = STATE_W'(state_q);
    assign instr_count = instr_count_q;

endmodule
